// File: rtl/collision_scheduler.sv
// collision_scheduler
// Purpose : once per frame, snapshot an object table and test every unordered
//           pair (i<j) for half-open rectangle overlap through one shared
//           2-stage comparator, one pair per clock.
// Ports   : clk, resetN (async, active-low); frame_start (1-cycle request);
//           obj_valid/obj_top/obj_left/obj_width/obj_height (object table);
//           busy, done (1-cycle), collided (per object), pair_count,
//           player_hit (1-cycle, with done), overrun (sticky).
// Latency : done is high P+3 cycles after frame_start is sampled,
//           where P = NUM_OBJ*(NUM_OBJ-1)/2.
module collision_scheduler #(
  parameter  int NUM_OBJ = 8,
  localparam int P       = NUM_OBJ * (NUM_OBJ - 1) / 2,
  localparam int CW      = $clog2(P + 1)
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      frame_start,
  input  logic [NUM_OBJ-1:0]        obj_valid,
  input  logic [NUM_OBJ-1:0][31:0]  obj_top,
  input  logic [NUM_OBJ-1:0][31:0]  obj_left,
  input  logic [NUM_OBJ-1:0][31:0]  obj_width,
  input  logic [NUM_OBJ-1:0][31:0]  obj_height,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_OBJ-1:0]        collided,
  output logic [CW-1:0]             pair_count,
  output logic                      player_hit,
  output logic                      overrun
);

  localparam int IW = $clog2(NUM_OBJ);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_OBJ - 2);
  localparam logic [IW-1:0] LAST_J = IW'(NUM_OBJ - 1);

  typedef enum logic [2:0] {IDLE, SNAPSHOT, SCAN, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d;
  logic                 s1_vld_q, s1_vld_d;
  logic [IW-1:0]        s1_i_q, s1_j_q;
  logic [NUM_OBJ-1:0]   acc_flags_q, acc_flags_d;
  logic [CW-1:0]        acc_count_q, acc_count_d;
  logic [NUM_OBJ-1:0]   collided_q, collided_d;
  logic [CW-1:0]        pair_count_q, pair_count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 player_hit_q, player_hit_d;
  logic                 overrun_q, overrun_d;
  logic                 issue;
  logic                 hit;

  // Snapshot of the object table; frozen for the whole scan.
  logic [NUM_OBJ-1:0]       snap_vld_q;
  logic [NUM_OBJ-1:0][31:0] snap_top_q, snap_left_q, snap_w_q, snap_h_q;

  // Stage-1 operand registers for the pair in flight.
  logic signed [31:0] a_top_q, a_left_q, a_w_q, a_h_q;
  logic signed [31:0] b_top_q, b_left_q, b_w_q, b_h_q;
  logic               s1_ok_q;

  always_ff @(posedge clk) begin
    if (state_q == SNAPSHOT) begin
      snap_vld_q  <= obj_valid;
      snap_top_q  <= obj_top;
      snap_left_q <= obj_left;
      snap_w_q    <= obj_width;
      snap_h_q    <= obj_height;
    end
  end

  // Degenerate (non-positive size) or invalid objects are resolved here so
  // stage 2 only has to do the four edge comparisons.
  always_ff @(posedge clk) begin
    if (issue) begin
      a_top_q  <= snap_top_q[i_q];
      a_left_q <= snap_left_q[i_q];
      a_w_q    <= snap_w_q[i_q];
      a_h_q    <= snap_h_q[i_q];
      b_top_q  <= snap_top_q[j_q];
      b_left_q <= snap_left_q[j_q];
      b_w_q    <= snap_w_q[j_q];
      b_h_q    <= snap_h_q[j_q];
      s1_ok_q  <= snap_vld_q[i_q] && snap_vld_q[j_q]
               && ($signed(snap_w_q[i_q]) > 0) && ($signed(snap_h_q[i_q]) > 0)
               && ($signed(snap_w_q[j_q]) > 0) && ($signed(snap_h_q[j_q]) > 0);
    end
  end

  // Stage 2: half-open overlap; sums wrap in 32-bit two's complement.
  logic signed [31:0] a_right, a_bottom, b_right, b_bottom;
  always_comb begin
    a_right  = a_left_q + a_w_q;
    a_bottom = a_top_q  + a_h_q;
    b_right  = b_left_q + b_w_q;
    b_bottom = b_top_q  + b_h_q;
    hit = s1_vld_q && s1_ok_q
       && (a_left_q < b_right)  && (b_left_q < a_right)
       && (a_top_q  < b_bottom) && (b_top_q  < a_bottom);
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    issue        = 1'b0;
    acc_flags_d  = acc_flags_q;
    acc_count_d  = acc_count_q;
    collided_d   = collided_q;
    pair_count_d = pair_count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    player_hit_d = 1'b0;
    overrun_d    = overrun_q;

    // Any request outside IDLE (including the DONE cycle) is dropped.
    if (frame_start && (state_q != IDLE)) overrun_d = 1'b1;

    if (hit) begin
      acc_flags_d[s1_i_q] = 1'b1;
      acc_flags_d[s1_j_q] = 1'b1;
      acc_count_d         = acc_count_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SNAPSHOT;
          busy_d  = 1'b1;
        end
      end
      SNAPSHOT: begin
        acc_flags_d = '0;
        acc_count_d = '0;
        i_d         = '0;
        j_d         = IW'(1);
        state_d     = SCAN;
      end
      SCAN: begin
        issue = 1'b1;
        if ((i_q == LAST_I) && (j_q == LAST_J)) begin
          state_d = DRAIN;
        end else if (j_q == LAST_J) begin
          i_d = i_q + IW'(1);
          j_d = i_q + IW'(2);
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        collided_d   = acc_flags_q;
        pair_count_d = acc_count_q;
        done_d       = 1'b1;
        player_hit_d = acc_flags_q[0];
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s1_vld_d = issue;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      s1_vld_q     <= 1'b0;
      s1_i_q       <= '0;
      s1_j_q       <= '0;
      acc_flags_q  <= '0;
      acc_count_q  <= '0;
      collided_q   <= '0;
      pair_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      player_hit_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      s1_vld_q     <= s1_vld_d;
      if (issue) begin
        s1_i_q     <= i_q;
        s1_j_q     <= j_q;
      end
      acc_flags_q  <= acc_flags_d;
      acc_count_q  <= acc_count_d;
      collided_q   <= collided_d;
      pair_count_q <= pair_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      player_hit_q <= player_hit_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign collided   = collided_q;
  assign pair_count = pair_count_q;
  assign player_hit = player_hit_q;
  assign overrun    = overrun_q;

endmodule
